// File: rtl/simon_pkg.sv
// Shared SIMON definitions: z sequences, FSM states, round constant, legality.
// Decrypt support in the cores is enabled with SIMON_DECRYPT_EN.
package simon_pkg;

    typedef enum logic [1:0] {IDLE, EXPAND, RUN, DONE} state_e;

    // Written in paper order: leftmost character is z[0].
    localparam logic [61:0] Z0 =
        62'b11111010001001010110000111001101111101000100101011000011100110;
    localparam logic [61:0] Z1 =
        62'b10001110111110010011000010110101000111011111001001100001011010;
    localparam logic [61:0] Z2 =
        62'b10101111011100000011010010011000101000010001111110010110110011;
    localparam logic [61:0] Z3 =
        62'b11011011101011000110010111100000010010001010011100110100001111;
    localparam logic [61:0] Z4 =
        62'b11010001111001101011011000100000010111000011001010010011101111;

    function automatic logic z_bit(input int j, input int idx);
        logic [61:0] s;
        logic [5:0]  b;
        case (j)
            0:       s = Z0;
            1:       s = Z1;
            2:       s = Z2;
            3:       s = Z3;
            default: s = Z4;
        endcase
        b = 6'(61 - idx);
        return s[b];
    endfunction

    function automatic logic [63:0] simon_c(input int w);
        return ({64{1'b1}} >> (64 - w)) & ~64'd3;
    endfunction

    function automatic bit simon_params_ok(input int w, input int m,
                                           input int t, input int j);
        return (w == 16 || w == 24 || w == 32 || w == 48 || w == 64) &&
               (m >= 2 && m <= 4) && (t > m) && (t <= 72) &&
               (j >= 0 && j <= 4);
    endfunction

endpackage

// File: rtl/simon_key_sched.sv
// SIMON key window with forward step and (SIMON_DECRYPT_EN) inverse step.
// Window position 0 holds the oldest round key, position m-1 the newest.
module simon_key_sched
    import simon_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int KEY_WORDS = 4,
    parameter int Z_IDX     = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          load_i,
    input  logic                          step_i,
    input  logic                          dir_i,
    input  logic [KEY_WORDS*WORD_W-1:0]   key_i,
    input  logic [6:0]                    r_i,
    output logic [WORD_W-1:0]             k_lo_o,
    output logic [WORD_W-1:0]             k_hi_o
);

    localparam logic [63:0]       C_FULL = simon_c(WORD_W);
    localparam logic [WORD_W-1:0] C      = C_FULL[WORD_W-1:0];

    logic [WORD_W-1:0] win_q [KEY_WORDS];
    logic [WORD_W-1:0] win_d [KEY_WORDS];
    logic [WORD_W-1:0] tap_f, tmp_f, k_new;
    logic              z_f;

    function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] v,
                                               input int s);
        return (v >> s) | (v << (WORD_W - s));
    endfunction

    if (KEY_WORDS == 4) begin : g_tap_f4
        assign tap_f = win_q[1];
    end else begin : g_tap_f
        assign tap_f = '0;
    end

    always_comb begin
        tmp_f = rotr(win_q[KEY_WORDS-1], 3) ^ tap_f;
        tmp_f = tmp_f ^ rotr(tmp_f, 1);
    end

    assign z_f   = z_bit(Z_IDX, int'(r_i) % 62);
    assign k_new = C ^ WORD_W'(z_f) ^ win_q[0] ^ tmp_f;

`ifdef SIMON_DECRYPT_EN
    logic [WORD_W-1:0] tap_i, tmp_i, k_old;
    logic              z_i;

    if (KEY_WORDS == 4) begin : g_tap_i4
        assign tap_i = win_q[0];
    end else begin : g_tap_i
        assign tap_i = '0;
    end

    always_comb begin
        tmp_i = rotr(win_q[KEY_WORDS-2], 3) ^ tap_i;
        tmp_i = tmp_i ^ rotr(tmp_i, 1);
    end

    // Recovers k[r-m]; garbage for r < m is shifted out before use.
    assign z_i   = z_bit(Z_IDX, (int'(r_i) + 62 - KEY_WORDS) % 62);
    assign k_old = win_q[KEY_WORDS-1] ^ C ^ WORD_W'(z_i) ^ tmp_i;
`else
    logic unused_dir;
    assign unused_dir = dir_i;
`endif

    always_comb begin
        win_d = win_q;
        if (load_i) begin
            for (int i = 0; i < KEY_WORDS; i++)
                win_d[i] = key_i[i*WORD_W +: WORD_W];
        end else if (step_i) begin
`ifdef SIMON_DECRYPT_EN
            if (dir_i) begin
                for (int i = 1; i < KEY_WORDS; i++)
                    win_d[i] = win_q[i-1];
                win_d[0] = k_old;
            end else
`endif
            begin
                for (int i = 0; i < KEY_WORDS - 1; i++)
                    win_d[i] = win_q[i+1];
                win_d[KEY_WORDS-1] = k_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < KEY_WORDS; i++)
                win_q[i] <= '0;
        end else begin
            win_q <= win_d;
        end
    end

    assign k_lo_o = win_q[0];
    assign k_hi_o = win_q[KEY_WORDS-1];

endmodule

// File: rtl/simon_block_core.sv
// Iterative SIMON engine, one round per clock, valid/ready on both sides.
// Define SIMON_DECRYPT_EN to enable mode=1 decryption.
module simon_block_core
    import simon_pkg::*;
#(
    parameter int WORD_W    = 16,
    parameter int KEY_WORDS = 4,
    parameter int ROUNDS    = 32,
    parameter int Z_IDX     = 0
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic                          mode,
    input  logic [KEY_WORDS*WORD_W-1:0]   key,
    input  logic [2*WORD_W-1:0]           blk_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [2*WORD_W-1:0]           blk_out
);

    if (!simon_params_ok(WORD_W, KEY_WORDS, ROUNDS, Z_IDX)) begin : g_bad
        $error("simon_block_core: illegal parameter combination");
    end

    localparam logic [6:0] R_LAST = 7'(ROUNDS - 1);

    state_e            state_q, state_d;
    logic [6:0]        r_q, r_d;
    logic [WORD_W-1:0] x_q, x_d, y_q, y_d;
    logic [WORD_W-1:0] k_lo, k_hi;
    logic              load, step, dir;

    function automatic logic [WORD_W-1:0] rotl(input logic [WORD_W-1:0] v,
                                               input int s);
        return (v << s) | (v >> (WORD_W - s));
    endfunction

    function automatic logic [WORD_W-1:0] f(input logic [WORD_W-1:0] v);
        return (rotl(v, 1) & rotl(v, 8)) ^ rotl(v, 2);
    endfunction

`ifdef SIMON_DECRYPT_EN
    localparam logic [6:0] X_LAST = 7'(ROUNDS - KEY_WORDS - 1);
    logic dec_q, dec_d;

    assign dir = dec_q & (state_q == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) dec_q <= 1'b0;
        else        dec_q <= dec_d;
    end
`else
    logic unused_sink;
    assign dir         = 1'b0;
    assign unused_sink = ^{mode, k_hi};
`endif

    always_comb begin
        state_d = state_q;
        r_d     = r_q;
        x_d     = x_q;
        y_d     = y_q;
        load    = 1'b0;
        step    = 1'b0;
`ifdef SIMON_DECRYPT_EN
        dec_d   = dec_q;
`endif
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    load = 1'b1;
                    x_d  = blk_in[2*WORD_W-1:WORD_W];
                    y_d  = blk_in[WORD_W-1:0];
                    r_d  = '0;
`ifdef SIMON_DECRYPT_EN
                    dec_d   = mode;
                    state_d = mode ? EXPAND : RUN;
`else
                    state_d = RUN;
`endif
                end
            end
`ifdef SIMON_DECRYPT_EN
            EXPAND: begin
                step = 1'b1;
                if (r_q == X_LAST) begin
                    r_d     = R_LAST;
                    state_d = RUN;
                end else begin
                    r_d = r_q + 7'd1;
                end
            end
`endif
            RUN: begin
                step = 1'b1;
`ifdef SIMON_DECRYPT_EN
                if (dec_q) begin
                    x_d = y_q;
                    y_d = x_q ^ f(y_q) ^ k_hi;
                    if (r_q == '0) state_d = DONE;
                    else           r_d     = r_q - 7'd1;
                end else
`endif
                begin
                    x_d = y_q ^ f(x_q) ^ k_lo;
                    y_d = x_q;
                    r_d = r_q + 7'd1;
                    if (r_q == R_LAST) state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            r_q     <= '0;
            x_q     <= '0;
            y_q     <= '0;
        end else begin
            state_q <= state_d;
            r_q     <= r_d;
            x_q     <= x_d;
            y_q     <= y_d;
        end
    end

    simon_key_sched #(
        .WORD_W    (WORD_W),
        .KEY_WORDS (KEY_WORDS),
        .Z_IDX     (Z_IDX)
    ) u_ks (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .step_i (step),
        .dir_i  (dir),
        .key_i  (key),
        .r_i    (r_q),
        .k_lo_o (k_lo),
        .k_hi_o (k_hi)
    );

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign blk_out   = out_valid ? {x_q, y_q} : '0;

endmodule

// File: doc/simon_block_core.md
Name: simon_block_core

Overview:
- Iterative SIMON block-cipher engine, one round per clock. Sits behind the SPI front end in the tt_um top, which shifts key and block in and result out.
- Successor to the fixed Simon32/64 datapath: word width, key words, round count and z-sequence are parameters.
- Adds a valid/ready handshake and an optional decrypt mode that uses an on-the-fly inverse key schedule, so no round-key RAM is needed.

Parameters:
- WORD_W, 16, word size n in bits (legal: 16, 24, 32, 48, 64); block is 2*WORD_W.
- KEY_WORDS, 4, key words m (legal: 2, 3, 4).
- ROUNDS, 32, round count T (must be greater than KEY_WORDS and at most 72).
- Z_IDX, 0, constant-sequence selector j (0..4).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  request holds a valid key, block and mode
- in_ready  out  1  core idle and able to accept a request
- mode  in  1  0 = encrypt, 1 = decrypt (decrypt only when SIMON_DECRYPT_EN is defined)
- key  in  KEY_WORDS*WORD_W  key {k[m-1],...,k[0]}, with k[0] in the LSBs
- blk_in  in  2*WORD_W  input block {x,y}, with x in the MSBs
- out_valid  out  1  blk_out is valid
- out_ready  in  1  consumer accepts blk_out
- blk_out  out  2*WORD_W  result {x,y}

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - in_ready=1, out_valid=0, blk_out=0.
  - Round counter, key window and data registers all clear.
- States are IDLE, EXPAND, RUN and DONE.
- IDLE:
  - in_ready=1.
  - On in_valid, latch key into an m-word key window, blk_in into x/y, and mode. Clear round counter r.
  - Next state is RUN for encrypt, EXPAND for decrypt.
  - in_ready drops the cycle after acceptance.
- Round function: f(v) = (rotl1(v) & rotl8(v)) ^ rotl2(v).
- Key step (forward), with c = 2^n - 4 and z = Z[Z_IDX][r mod 62]:
  - tmp = rotr3(k[m-1]).
  - If m==4, tmp ^= k[1].
  - tmp ^= rotr1(tmp).
  - k_new = c ^ z ^ k[0] ^ tmp.
  - Shift the window down by one; k_new enters k[m-1].
- RUN, encrypt:
  - Each cycle: (x,y) <= (y ^ f(x) ^ k[0], x); the key window steps forward; r++.
  - After ROUNDS cycles, go to DONE.
- EXPAND (decrypt only):
  - Step the key window forward ROUNDS-KEY_WORDS times with no data update.
  - The window then holds k[T-m..T-1]. Set r = T-1 and go to RUN.
- RUN, decrypt:
  - Each cycle: (x,y) <= (y, x ^ f(y) ^ k[m-1]).
  - Inverse key step: recover k_old = k[m-1] ^ c ^ z(r-m) ^ tmp, where tmp is computed from the words currently at window positions m-2 and m-4 (per m).
  - Shift the window up; r--. After ROUNDS cycles, go to DONE.
- DONE:
  - out_valid=1 and blk_out={x,y}; both stay stable until out_ready.
  - The handshake completes when out_valid and out_ready are both high. Next state is IDLE with out_valid=0.
- Latency from accept to out_valid:
  - Encrypt: ROUNDS+1 cycles.
  - Decrypt: 2*ROUNDS-KEY_WORDS+1 cycles.
- Simultaneous events:
  - in_valid while busy is ignored and must be held by the source.
  - out_ready without out_valid has no effect.
  - Back-to-back requests take at least one idle cycle.
- Reset mid-operation aborts immediately and returns to the reset state. No partial output is ever flagged valid.
- Arithmetic: all rotations are modulo WORD_W; XOR/AND only, no carries. z index wraps modulo 62.

Optional Feature:
- Macro SIMON_DECRYPT_EN.
- Defined: mode=1 performs decryption via EXPAND plus the inverse schedule.
- Undefined:
  - mode is ignored and every request is an encrypt.
  - The EXPAND state and inverse-key logic are not synthesised.
  - mode must still be a port, unused and tied to the unused-signal sink.

Decomposition:
- Package simon_pkg:
  - The five 62-bit z sequences Z[0..4].
  - The state enum {IDLE, EXPAND, RUN, DONE}.
  - A function for c given WORD_W.
  - Parameter-legality checks.
- One sub-module, simon_key_sched: the key window plus forward/inverse step, with control ports step, dir and load.

Test Plan:
- Simon32/64, default parameters, encrypt. key=1918_1110_0908_0100, blk_in=6565_6877 -> blk_out=c69b_e9bb, out_valid asserted exactly 33 cycles after accept.
- Same configuration with SIMON_DECRYPT_EN, mode=1, blk_in=c69b_e9bb -> blk_out=6565_6877 after 61 cycles.
- WORD_W=32, KEY_WORDS=4, ROUNDS=44, Z_IDX=3. key=1b1a1918_13121110_0b0a0908_03020100, pt=656b696c_20646e75 -> ct=44c8fc20_b9dfa07a; decrypt round-trips back to pt.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> blk_out is stable, in_ready=0, and a second in_valid is not accepted until the handshake completes.
- Async rst_n pulse at round 15 of an encrypt -> out_valid=0, in_ready=1 immediately. A fresh request then yields the correct c69b_e9bb.
- Without SIMON_DECRYPT_EN, mode=1 on the 32/64 vector -> encrypt result c69b_e9bb after 33 cycles.
